// File: rtl/dmem_arb_defs.sv
// Shared definitions for the data-memory arbiter: FSM encodings and port IDs.
package dmem_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_rr_pick2.sv
// Two-way round-robin pick: rr_ptr breaks the tie when both ports request.
module dmem_rr_pick2
  import dmem_arb_defs::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic win
);

  always_comb begin
    win = PORT_CPU;
    if (req0 && req1) win = rr_ptr;
    else if (req1)    win = PORT_DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between CPU (port 0) and DMA (port 1).
// Optional DMEM_ARB_RANGE_EN: out-of-range accesses complete the handshake but never reach memory.
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int MEM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_d_in,
  output logic              mem_mrd,
  output logic              mem_mwr,
  input  logic [DATA_W-1:0] mem_d_out
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [1:0]             req, we, lock;
  logic [1:0][ADDR_W-1:0] adr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic [1:0]             rvalid_q, err_q;

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_nxt;
  logic             rr_ptr;

  logic owner, owned, gnt, cur_we, other_req, burst_ok, range_bad;
  logic idle_win, hand_win;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign lock  = {lock1, lock0};
  assign adr   = {adr1, adr0};
  assign wdata = {wdata1, wdata0};

  assign owned     = (state != IDLE);
  assign owner     = (state == OWN1);
  assign other_req = req[!owner];
  assign cur_we    = we[owner];

  // Reset gates the grant combinationally so no write commits in a reset cycle.
  assign gnt  = !rst && owned && req[owner];
  assign gnt0 = gnt && (owner == PORT_CPU);
  assign gnt1 = gnt && (owner == PORT_DMA);

  assign mem_adr  = owned ? adr[owner]   : '0;
  assign mem_d_in = owned ? wdata[owner] : '0;

`ifdef DMEM_ARB_RANGE_EN
  assign range_bad = owned && (adr[owner] > ADDR_W'(MEM_BYTES - 4));
`else
  assign range_bad = 1'b0;
`endif

  assign mem_mwr = gnt &&  cur_we && !range_bad;
  assign mem_mrd = gnt && !cur_we && !range_bad;

  assign cnt_nxt  = {1'b0, cnt} + 1'b1;
  assign burst_ok = lock[owner] && (cnt_nxt < (CNT_W+1)'(MAX_BURST));

  dmem_rr_pick2 u_pick_idle (
    .req0  (req0),
    .req1  (req1),
    .rr_ptr(rr_ptr),
    .win   (idle_win)
  );

  // Hand-over only considers the waiting (non-owner) port.
  dmem_rr_pick2 u_pick_hand (
    .req0  (req0 && owner),
    .req1  (req1 && !owner),
    .rr_ptr(rr_ptr),
    .win   (hand_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= PORT_CPU;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      if (gnt && !cur_we) begin
        rvalid_q[owner] <= 1'b1;
        rdata_q[owner]  <= range_bad ? '0 : mem_d_out;
      end
      if (gnt && range_bad) err_q[owner] <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (|req) state <= own_state(idle_win);
        end
        default: begin
          if (req[owner]) begin
            if (burst_ok) begin
              cnt <= cnt_nxt[CNT_W-1:0];
            end else begin
              cnt <= '0;
              if (other_req) begin
                state  <= own_state(hand_win);
                rr_ptr <= owner;
              end
            end
          end else begin
            cnt   <= '0;
            state <= other_req ? own_state(hand_win) : IDLE;
          end
        end
      endcase
    end
  end

  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata0  = rdata_q[0];
  assign rdata1  = rdata_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane memory model; honours DMEM_ARB_RANGE_EN.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] adr0, wdata0, adr1, wdata1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_adr, mem_d_in, mem_d_out;
  logic        mem_mrd, mem_mwr;

  logic [7:0]  mem [0:65535];
  logic [15:0] ma;
  int          errors, checks;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .adr0(adr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .lock1(lock1), .adr1(adr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
    .mem_d_out(mem_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte-lane memory, combinational read, posedge write.
  assign ma        = mem_adr[15:0];
  assign mem_d_out = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};

  always @(posedge clk)
    if (mem_mwr) begin
      mem[ma]         <= mem_d_in[7:0];
      mem[ma + 16'd1] <= mem_d_in[15:8];
      mem[ma + 16'd2] <= mem_d_in[23:16];
      mem[ma + 16'd3] <= mem_d_in[31:24];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; adr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; adr1 = '0; wdata1 = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[1000] = 8'h44; mem[1001] = 8'h33; mem[1002] = 8'h22; mem[1003] = 8'h11;

    // Reset state
    tick();
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_mwr", {31'd0, mem_mwr}, 32'd0);

    // 1. Single read by port 0, one IDLE bubble first
    rst = 0; req0 = 1; we0 = 0; adr0 = 32'd1000; #1;
    chk("t1_bubble", {31'd0, gnt0}, 32'd0);
    tick();
    chk("t1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t1_mrd", {31'd0, mem_mrd}, 32'd1);
    chk("t1_adr", mem_adr, 32'd1000);
    tick(); req0 = 0;
    chk("t1_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("t1_rdata0", rdata0, 32'h11223344);
    tick();
    chk("t1_rvalid0_pulse", {31'd0, rvalid0}, 32'd0);
    chk("t1_rdata0_hold", rdata0, 32'h11223344);

    // 2. Port 1 write then read back
    req1 = 1; we1 = 1; adr1 = 32'd2000; wdata1 = 32'hDEADBEEF; #1;
    chk("t2_bubble", {31'd0, gnt1}, 32'd0);
    tick();
    chk("t2_gnt1_wr", {31'd0, gnt1}, 32'd1);
    chk("t2_mwr", {31'd0, mem_mwr}, 32'd1);
    chk("t2_d_in", mem_d_in, 32'hDEADBEEF);
    tick(); we1 = 0; #1;
    chk("t2_gnt1_rd", {31'd0, gnt1}, 32'd1);
    chk("t2_mrd", {31'd0, mem_mrd}, 32'd1);
    chk("t2_byte0", {24'd0, mem[2000]}, 32'h000000EF);
    chk("t2_byte3", {24'd0, mem[2003]}, 32'h000000DE);
    tick(); req1 = 0;
    chk("t2_rvalid1", {31'd0, rvalid1}, 32'd1);
    chk("t2_rdata1", rdata1, 32'hDEADBEEF);
    chk("t2_rvalid0", {31'd0, rvalid0}, 32'd0);
    tick();

    // 3. Contention from reset: strict alternation, port 0 first
    rst = 1; tick();
    rst = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0; adr0 = 32'd1000; adr1 = 32'd2000; #1;
    chk("t3_bubble", {30'd0, gnt1, gnt0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_gnt0_%0d", i), {31'd0, gnt0}, {31'd0, (i % 2 == 0)});
      chk($sformatf("t3_gnt1_%0d", i), {31'd0, gnt1}, {31'd0, (i % 2 == 1)});
      if (i > 0 && i % 2 == 1) chk($sformatf("t3_rd0_%0d", i), rdata0, 32'h11223344);
      if (i > 0 && i % 2 == 0) chk($sformatf("t3_rd1_%0d", i), rdata1, 32'hDEADBEEF);
    end
    req0 = 0; req1 = 0;
    tick();

    // 4. Locked burst of 6 with port 1 waiting from the 2nd access
    req0 = 1; lock0 = 1; adr0 = 32'd1000;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 1) req1 = 1;
      #1;
      chk($sformatf("t4_gnt0_%0d", k), {31'd0, gnt0}, 32'd1);
      chk($sformatf("t4_gnt1_%0d", k), {31'd0, gnt1}, 32'd0);
      tick();
    end
    req0 = 0; lock0 = 0; #1;
    chk("t4_handover_gap", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk("t4_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 0;
    tick();

    // 4b. Lock held past MAX_BURST=8: forced hand-over, then back
    req0 = 1; lock0 = 1;
    tick();
    req1 = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t4b_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, (k != 8)});
      chk($sformatf("t4b_gnt1_%0d", k), {31'd0, gnt1}, {31'd0, (k == 8)});
      if (k < 9) tick();
    end
    req0 = 0; req1 = 0; lock0 = 0;
    tick();

    // 5. Reset during a locked burst write
    req0 = 1; lock0 = 1; we0 = 0; adr0 = 32'd1000;
    tick();
    chk("t5_gnt0_rd", {31'd0, gnt0}, 32'd1);
    tick();
    we0 = 1; adr0 = 32'd3004; wdata0 = 32'h12345678; rst = 1; #1;
    chk("t5_rvalid_pre", {31'd0, rvalid0}, 32'd1);
    chk("t5_gnt0_rst", {31'd0, gnt0}, 32'd0);
    chk("t5_mwr_rst", {31'd0, mem_mwr}, 32'd0);
    tick(); rst = 0; #1;
    chk("t5_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("t5_rdata0", rdata0, 32'd0);
    chk("t5_mem", {mem[3007], mem[3006], mem[3005], mem[3004]}, 32'd0);
    chk("t5_idle", {31'd0, gnt0}, 32'd0);
    req0 = 0; lock0 = 0; we0 = 0;
    tick();

    // 6. Write at 65534 (past the last full word)
    req1 = 1; we1 = 1; adr1 = 32'd65534; wdata1 = 32'hA5A5A5A5;
    tick();
    chk("t6_gnt1", {31'd0, gnt1}, 32'd1);
`ifdef DMEM_ARB_RANGE_EN
    chk("t6_mwr", {31'd0, mem_mwr}, 32'd0);
`else
    chk("t6_mwr", {31'd0, mem_mwr}, 32'd1);
`endif
    tick(); req1 = 0;
`ifdef DMEM_ARB_RANGE_EN
    chk("t6_err1", {31'd0, err1}, 32'd1);
    chk("t6_mem", {24'd0, mem[65534]}, 32'd0);
`else
    chk("t6_err1", {31'd0, err1}, 32'd0);
    chk("t6_mem", {24'd0, mem[65534]}, 32'h000000A5);
`endif
    chk("t6_rvalid1", {31'd0, rvalid1}, 32'd0);
    tick();
    chk("t6_err1_pulse", {31'd0, err1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
